// File: rtl/ex_mem_if.sv
// ex_mem_if: execute-stage output bundle into the memory stage, plus the
// memory stage's back-pressure, branch and write-back results.
//   master: execute side; drives the instruction bundle, observes results
//   slave : memory stage; consumes the bundle, drives stall/PCSrc/wb_*
interface ex_mem_if;
    logic        in_valid;
    logic        flush;
    logic [31:0] ALUResult;
    logic        zero;
    logic [31:0] AddResult;
    logic [31:0] ALUReadData2;
    logic [4:0]  RdOrRt;
    logic        MemRead;
    logic        MemWrite;
    logic        Branch;
    logic        RegWrite;
    logic        MemtoReg;
    logic        stall;
    logic        PCSrc;
    logic [31:0] BranchTarget;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_reg;
    logic        wb_RegWrite;

    modport master (
        output in_valid, flush, ALUResult, zero, AddResult, ALUReadData2, RdOrRt,
               MemRead, MemWrite, Branch, RegWrite, MemtoReg,
        input  stall, PCSrc, BranchTarget, wb_valid, wb_data, wb_reg, wb_RegWrite
    );

    modport slave (
        input  in_valid, flush, ALUResult, zero, AddResult, ALUReadData2, RdOrRt,
               MemRead, MemWrite, Branch, RegWrite, MemtoReg,
        output stall, PCSrc, BranchTarget, wb_valid, wb_data, wb_reg, wb_RegWrite
    );
endinterface

// File: rtl/ex_mem_access.sv
// ex_mem_access: EX/MEM pipeline register, word-addressed data memory with
// MEM_LATENCY-cycle accesses, branch resolution and the MEM/WB register.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (memory contents are kept)
//   bus  : ex_mem_if.slave; instruction bundle in, stall/PCSrc/BranchTarget
//          and wb_valid/wb_data/wb_reg/wb_RegWrite out
module ex_mem_access #(
    parameter int ADDR_WIDTH  = 8,
    parameter int MEM_LATENCY = 2
) (
    input  logic     clk,
    input  logic     rst,
    ex_mem_if.slave  bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        ex_valid_q;
    logic [31:0] alu_q, add_q, wdata_q;
    logic [4:0]  rd_q;
    logic        zero_q, mem_read_q, mem_write_q, branch_q, reg_write_q, memto_reg_q;

    logic        wb_valid_q, wb_reg_write_q;
    logic [31:0] wb_data_q;
    logic [4:0]  wb_reg_q;

    logic [31:0] mem_q [2**ADDR_WIDTH];

    logic                  stall, take, mem_op, done;
    logic [ADDR_WIDTH-1:0] addr;

    assign addr = alu_q[ADDR_WIDTH+1:2];

    always_comb begin
        stall   = (state_q == BUSY) && (cnt_q != 4'd1);
        take    = bus.in_valid && !bus.flush;
        mem_op  = take && (bus.MemRead || bus.MemWrite);
        // ALU ops finish after one cycle in IDLE; memory ops finish on the
        // edge where the countdown reaches 1, which is also when stall drops.
        done    = ex_valid_q && !stall;
        state_d = stall ? BUSY : mem_op ? BUSY : IDLE;
        cnt_d   = stall ? cnt_q - 4'd1 : mem_op ? 4'(MEM_LATENCY) : 4'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q  <= 1'b0;
            alu_q       <= '0;
            add_q       <= '0;
            wdata_q     <= '0;
            rd_q        <= '0;
            zero_q      <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            branch_q    <= 1'b0;
            reg_write_q <= 1'b0;
            memto_reg_q <= 1'b0;
        end else if (!stall) begin
            ex_valid_q  <= take;
            alu_q       <= bus.ALUResult;
            add_q       <= bus.AddResult;
            wdata_q     <= bus.ALUReadData2;
            rd_q        <= bus.RdOrRt;
            zero_q      <= bus.zero;
            mem_read_q  <= bus.MemRead;
            mem_write_q <= bus.MemWrite;
            branch_q    <= bus.Branch;
            reg_write_q <= bus.RegWrite;
            memto_reg_q <= bus.MemtoReg;
        end
    end

    // The read below sees the pre-write word, giving read-before-write when
    // MemRead and MemWrite are both set; reset aborts a pending store.
    always_ff @(posedge clk) begin
        if (!rst && done && mem_write_q)
            mem_q[addr] <= wdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            wb_data_q      <= '0;
            wb_reg_q       <= '0;
        end else begin
            wb_valid_q     <= done;
            wb_reg_write_q <= done && reg_write_q;
            if (done) begin
                wb_data_q <= memto_reg_q ? mem_q[addr] : alu_q;
                wb_reg_q  <= rd_q;
            end
        end
    end

    assign bus.stall        = stall;
    assign bus.PCSrc        = ex_valid_q && branch_q && zero_q;
    assign bus.BranchTarget = add_q;
    assign bus.wb_valid     = wb_valid_q;
    assign bus.wb_data      = wb_data_q;
    assign bus.wb_reg       = wb_reg_q;
    assign bus.wb_RegWrite  = wb_reg_write_q;
endmodule

// File: tb/tb_ex_mem_access.sv
// tb_ex_mem_access: directed and random instruction streams against a
// schedule-based reference model of ex_mem_access.
module tb_ex_mem_access;
    localparam int LAT = 3;

    typedef struct packed {
        logic        v, fl;
        logic [31:0] alu, add, wd;
        logic [4:0]  rd;
        logic        z, mr, mw, br, rw, m2r;
    } ins_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ex_mem_if bus ();
    ex_mem_access #(.ADDR_WIDTH(8), .MEM_LATENCY(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: edge index, the edge from which the next instruction
    // may be accepted, and at most one instruction awaiting completion
    int          e = 0;
    int          free_at = 0;
    bit          pend = 0;
    int          pend_done = 0;
    ins_t        pend_i;
    logic [31:0] mem_m [256];
    logic        e_wbv, e_wbrw, e_pc, was_rst;
    logic [31:0] e_wbd, e_bt;
    logic [4:0]  e_wbr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input ins_t x);
        bus.in_valid     = x.v;
        bus.flush        = x.fl;
        bus.ALUResult    = x.alu;
        bus.AddResult    = x.add;
        bus.ALUReadData2 = x.wd;
        bus.RdOrRt       = x.rd;
        bus.zero         = x.z;
        bus.MemRead      = x.mr;
        bus.MemWrite     = x.mw;
        bus.Branch       = x.br;
        bus.RegWrite     = x.rw;
        bus.MemtoReg     = x.m2r;
    endtask

    task automatic model(input ins_t x, input logic r);
        int w, lat;
        e++;
        was_rst = r;
        if (r) begin
            pend = 0; free_at = e + 1;
            e_wbv = 0; e_wbrw = 0; e_wbd = 0; e_wbr = 0; e_pc = 0; e_bt = 0;
            return;
        end
        e_wbv  = pend && (pend_done == e);
        e_wbrw = 0;
        if (e_wbv) begin
            w      = int'((pend_i.alu >> 2) % 256);
            e_wbd  = pend_i.m2r ? mem_m[w] : pend_i.alu;
            e_wbr  = pend_i.rd;
            e_wbrw = pend_i.rw;
            if (pend_i.mw) mem_m[w] = pend_i.wd;
            pend = 0;
        end
        if (e >= free_at) begin
            e_pc = x.v && !x.fl && x.br && x.z;
            e_bt = x.add;
            if (x.v && !x.fl) begin
                lat = (x.mr || x.mw) ? LAT : 1;
                pend = 1; pend_done = e + lat; pend_i = x; free_at = e + lat;
            end else
                free_at = e + 1;
        end
    endtask

    task automatic step(input ins_t x, input logic r);
        drive(x);
        rst = r;
        @(posedge clk);
        model(x, r);
        #1;
        chk("stall", 32'(bus.stall), 32'(e + 1 < free_at));
        chk("wb_valid", 32'(bus.wb_valid), 32'(e_wbv));
        chk("wb_RegWrite", 32'(bus.wb_RegWrite), 32'(e_wbrw));
        chk("PCSrc", 32'(bus.PCSrc), 32'(e_pc));
        if (e_wbv || was_rst) begin
            chk("wb_data", bus.wb_data, e_wbd);
            chk("wb_reg", 32'(bus.wb_reg), 32'(e_wbr));
        end
        if (e_pc || was_rst) chk("BranchTarget", bus.BranchTarget, e_bt);
    endtask

    // present x until accepted, holding it through stalls
    task automatic issue(input ins_t x);
        bit acc;
        for (int k = 0; k < 20; k++) begin
            acc = (e + 1 >= free_at);
            step(x, 1'b0);
            if (acc) return;
        end
        chk("issue_timeout", 32'd1, 32'd0);
    endtask

    function automatic ins_t mk(input logic mr, input logic mw, input logic [31:0] alu,
                                input logic [31:0] wd, input logic [4:0] rd);
        ins_t x = '0;
        x.v = 1; x.mr = mr; x.mw = mw; x.alu = alu; x.wd = wd; x.rd = rd;
        x.rw = !mw || mr; x.m2r = mr;
        return x;
    endfunction

    function automatic ins_t gen();
        ins_t        x = '0;
        logic [31:0] r = $urandom();
        logic [3:0]  w = 4'($urandom_range(0, 15));
        int          k = $urandom_range(0, 3);
        x.v   = ($urandom_range(0, 7) != 0);
        x.fl  = ($urandom_range(0, 9) == 0);
        x.add = $urandom();
        x.wd  = $urandom();
        x.rd  = 5'($urandom());
        x.z   = 1'($urandom());
        x.alu = (k == 1 || k == 2) ? {r[31:10], 4'b0, w, r[1:0]} : $urandom();
        x.mr  = (k == 1) || (k == 2 && $urandom_range(0, 7) == 0);
        x.mw  = (k == 2);
        x.br  = (k == 3);
        x.m2r = x.mr;
        x.rw  = (k == 0) ? 1'($urandom()) : x.mr;
        return x;
    endfunction

    initial begin
        ins_t b = '0;
        ins_t x;
        ins_t cur = '0;
        for (int i = 0; i < 256; i++) mem_m[i] = '0;
        step(b, 1'b1);
        step(b, 1'b1);
        for (int i = 0; i < 16; i++) issue(mk(1'b0, 1'b1, 32'(i * 4), $urandom(), 5'd0));
        step(b, 1'b0);
        // ALU op
        x = mk(1'b0, 1'b0, 32'h1234, 32'h0, 5'd5);
        issue(x);
        step(b, 1'b0);
        chk("alu_wb_data", bus.wb_data, 32'h1234);
        step(b, 1'b0);
        // store then back-to-back load
        issue(mk(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 5'd0));
        issue(mk(1'b1, 1'b0, 32'h10, 32'h0, 5'd9));
        for (int i = 0; i < LAT; i++) step(b, 1'b0);
        chk("load_after_store", mem_m[4], 32'hDEADBEEF);
        // address wrap and alignment
        issue(mk(1'b0, 1'b1, 32'h403, 32'hA5A5A5A5, 5'd0));
        issue(mk(1'b1, 1'b0, 32'h0, 32'h0, 5'd3));
        for (int i = 0; i < LAT; i++) step(b, 1'b0);
        // read-before-write
        issue(mk(1'b1, 1'b1, 32'h8, 32'h5A5A5A5A, 5'd7));
        for (int i = 0; i < LAT; i++) step(b, 1'b0);
        // branch taken / not taken
        x = '0; x.v = 1; x.br = 1; x.z = 1; x.add = 32'h40;
        issue(x);
        chk("branch_target", bus.BranchTarget, 32'h40);
        x.z = 0;
        issue(x);
        step(b, 1'b0);
        // flush overrides in_valid
        x = mk(1'b0, 1'b0, 32'h77, 32'h0, 5'd4); x.fl = 1;
        issue(x);
        step(b, 1'b0);
        // reset during the second busy cycle aborts the store
        issue(mk(1'b0, 1'b1, 32'h20, 32'h11111111, 5'd0));
        step(b, 1'b0);
        step(b, 1'b1);
        issue(mk(1'b1, 1'b0, 32'h20, 32'h0, 5'd2));
        for (int i = 0; i < LAT; i++) step(b, 1'b0);
        // random stream, instruction held while stalled
        for (int i = 0; i < 3000; i++) begin
            if (e + 1 >= free_at) cur = gen();
            step(cur, 1'($urandom_range(0, 59) == 0));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ex_mem_access.md
Name: ex_mem_access

Overview:
- Consumer end of the execute-stage output bundle: ALUResult, zero, AddResult, ReadData2 and RdOrRt plus control bits.
- Contains the EX/MEM pipeline register, a word-addressed data memory with configurable access latency, and the branch-resolution output back to fetch.
- Produces the MEM/WB register contents for write-back.
- Back-pressures the execute stage with `stall` while a multi-cycle memory access is in flight.

Parameters:
- ADDR_WIDTH, 8, word-address bits; memory depth = 2**ADDR_WIDTH words of 32 bits.
- MEM_LATENCY, 2, cycles per load/store access; legal values 1..15.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  execute stage presents a valid instruction
- flush  in  1  discard the instruction presented this cycle (insert bubble)
- ALUResult  in  32  ALU result / memory byte address
- zero  in  1  ALU zero flag
- AddResult  in  32  branch target
- ALUReadData2  in  32  store data
- RdOrRt  in  5  destination register
- MemRead, MemWrite, Branch, RegWrite, MemtoReg  in  1 each  control bits
- stall  out  1  execute stage must hold its outputs; input not captured
- PCSrc  out  1  take branch
- BranchTarget  out  32  registered AddResult
- wb_valid  out  1  MEM/WB holds a completed instruction (one-cycle pulse per instruction)
- wb_data  out  32  MemtoReg ? memory read data : ALUResult
- wb_reg  out  5  destination register
- wb_RegWrite  out  1  RegWrite & wb_valid

Behaviour:
- Capture: at an edge where in_valid=1, flush=0 and stall=0, the EX/MEM register loads all inputs and sets ex_valid=1. flush=1 or in_valid=0 at a non-stalled edge loads a bubble (ex_valid=0). flush overrides in_valid. flush has no effect on an access already in flight.
- FSM:
  - States are IDLE and BUSY, with a 4-bit down counter cnt.
  - Capture of a load/store moves the FSM to BUSY with cnt=MEM_LATENCY.
  - Capture of any other instruction keeps IDLE with an effective latency of 1.
  - In BUSY, cnt decrements each edge. The access completes at the edge where cnt==1, and the FSM returns to IDLE or re-enters BUSY if a new load/store is captured on that same edge.
- stall (combinational) = (state==BUSY) && (cnt!=1). With MEM_LATENCY=1, stall is never asserted. On the completing edge a new instruction is accepted (back-to-back, no bubble).
- Latency: capture edge E0; the MEM/WB register is written at edge E0+1 for ALU ops and at edge E0+MEM_LATENCY for loads/stores. wb_valid is high for exactly the one cycle following that edge. Bubbles produce wb_valid=0.
- Address: word index = ALUResult[ADDR_WIDTH+1:2]. Bits [1:0] and bits above ADDR_WIDTH+1 are ignored, so the address wraps modulo depth.
- Store: the memory word is written with ALUReadData2 at the completing edge only.
- Load: memory is read at the completing edge into wb_data (when MemtoReg=1).
- MemRead and MemWrite both set: the store is performed, and wb_data returns the pre-write contents (read-before-write).
- Branch:
  - PCSrc = ex_valid & Branch & zero, from the EX/MEM register. It is high for the cycle(s) the branch occupies EX/MEM, which is one cycle since branches are not memory ops.
  - BranchTarget = registered AddResult, valid whenever PCSrc=1.
- Reset:
  - Applies at any edge with rst=1, including mid-access.
  - FSM goes to IDLE, cnt=0, ex_valid=0, and the in-flight store is aborted with no memory write.
  - Outputs: stall=0, PCSrc=0, BranchTarget=0, wb_valid=0, wb_data=0, wb_reg=0, wb_RegWrite=0.
  - Memory contents are not reset.
- Simultaneous rst and flush: rst wins.

Test Plan:
- ALU op (MEM_LATENCY=2): in_valid=1, ALUResult=0x1234, RdOrRt=5, RegWrite=1, MemtoReg=0 -> wb_valid, wb_data=0x1234, wb_reg=5, wb_RegWrite=1 one cycle after the capture edge; stall never high.
- Store then load: store ALUReadData2=0xDEADBEEF at ALUResult=0x10 -> stall high for 1 cycle, wb_RegWrite=0. Then load from 0x10 with RdOrRt=9 -> wb_data=0xDEADBEEF two edges after capture, with no bubble between the two.
- Wrap/alignment (ADDR_WIDTH=8): store 0xA5A5A5A5 to 0x00000403, load from 0x00000000 -> wb_data=0xA5A5A5A5.
- Branch: Branch=1, zero=1, AddResult=0x40 -> PCSrc=1 and BranchTarget=0x40 for one cycle. Same with zero=0 -> PCSrc=0.
- Flush/stall: flush=1 with in_valid=1 -> no wb_valid. Instruction held during stall is captured exactly once, producing a single wb_valid pulse.
- Reset mid-store (MEM_LATENCY=3): rst at the 2nd BUSY cycle -> all outputs 0 next cycle. A subsequent load shows the pre-store contents of that address, proving the store was aborted.
